// File: rtl/mem_pkg.sv
// mem_pkg: opcode, byte-enable and FSM definitions shared by the mem_access block.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {IDLE, WAIT} state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory request/response bus between the MEM stage and data memory.
interface mem_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half lane of a little-endian read word and extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[8*lane +: 8];
        h    = lane[1] ? rdata[31:16] : rdata[15:0];
        data = op == OP_LB  ? {{24{b[7]}}, b} :
               op == OP_LBU ? {24'h0, b} :
               op == OP_LH  ? {{16{h[15]}}, h} :
               op == OP_LHU ? {16'h0, h} : rdata;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with ack timeout; MEM_MISALIGN_TRAP_EN traps misaligned
// accesses instead of forcing the offending low address bits to zero.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         MEM_result,
    input  logic                MEM_writeEnable,
    input  logic [4:0]          MEM_writeAddress,
    input  logic [5:0]          MEM_ALUopcode,
    input  logic [31:0]         MEM_memoryAddress,
    input  logic [31:0]         MEM_memoryData,
    mem_access_if.master        dmem,
    output logic                stall_req,
    output logic [31:0]         WB_result,
    output logic                WB_writeEnable,
    output logic [4:0]          WB_writeAddress,
    output logic                bus_err,
    output logic                misalign
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [31:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]   dmem_wdata_q, dmem_wdata_d;
    logic [3:0]    dmem_be_q, dmem_be_d;
    logic [5:0]    op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic          pend_we_q, pend_we_d;
    logic [4:0]    pend_wa_q, pend_wa_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   wb_result_q, wb_result_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_wa_q, wb_wa_d;
    logic          bus_err_q, bus_err_d;
    logic          misalign_q, misalign_d;

    logic          mem_op, is_word, is_half, is_store, misaligned, go, timeout;
    logic [1:0]    lane;
    logic [31:0]   load_data;

    mem_load_align u_align (
        .op    (op_q),
        .lane  (lane_q),
        .rdata (dmem.dmem_rdata),
        .data  (load_data)
    );

    always_comb begin
        mem_op   = is_mem_op(MEM_ALUopcode);
        is_word  = MEM_ALUopcode inside {OP_LW, OP_SW};
        is_half  = MEM_ALUopcode inside {OP_LH, OP_LHU, OP_SH};
        is_store = MEM_ALUopcode inside {OP_SB, OP_SH, OP_SW};
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = is_word ? |MEM_memoryAddress[1:0] : is_half & MEM_memoryAddress[0];
        lane       = MEM_memoryAddress[1:0];
`else
        misaligned = 1'b0;
        lane       = is_word ? 2'b00 : is_half ? {MEM_memoryAddress[1], 1'b0} : MEM_memoryAddress[1:0];
`endif
        go        = state_q == IDLE && mem_op && !misaligned;
        timeout   = cnt_q == CW'(TIMEOUT_CYCLES - 1);
        stall_req = go || (state_q == WAIT && !dmem.dmem_ack);
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        op_d         = op_q;
        lane_d       = lane_q;
        pend_we_d    = pend_we_q;
        pend_wa_d    = pend_wa_q;
        cnt_d        = cnt_q;
        wb_result_d  = wb_result_q;
        wb_we_d      = 1'b0;
        wb_wa_d      = wb_wa_q;
        bus_err_d    = 1'b0;
        misalign_d   = 1'b0;
        if (state_q == IDLE) begin
            if (go) begin
                state_d      = WAIT;
                dmem_req_d   = 1'b1;
                dmem_we_d    = is_store;
                dmem_addr_d  = {MEM_memoryAddress[31:2], 2'b00};
                dmem_be_d    = is_word ? BE_WORD : is_half ? BE_HALF << {lane[1], 1'b0} : BE_BYTE << lane;
                dmem_wdata_d = is_word ? MEM_memoryData :
                               is_half ? {2{MEM_memoryData[15:0]}} : {4{MEM_memoryData[7:0]}};
                op_d         = MEM_ALUopcode;
                lane_d       = lane;
                pend_we_d    = MEM_writeEnable && !is_store;
                pend_wa_d    = MEM_writeAddress;
                cnt_d        = '0;
            end else begin
                // plain ALU result, or a trapped misaligned access written back disabled
                wb_result_d = MEM_result;
                wb_we_d     = MEM_writeEnable && !mem_op;
                wb_wa_d     = MEM_writeAddress;
                misalign_d  = misaligned;
            end
        end else if (dmem.dmem_ack) begin
            state_d     = IDLE;
            dmem_req_d  = 1'b0;
            wb_result_d = load_data;
            wb_we_d     = pend_we_q;
            wb_wa_d     = pend_wa_q;
        end else if (timeout) begin
            state_d    = IDLE;
            dmem_req_d = 1'b0;
            wb_wa_d    = pend_wa_q;
            bus_err_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            op_q         <= '0;
            lane_q       <= '0;
            pend_we_q    <= 1'b0;
            pend_wa_q    <= '0;
            cnt_q        <= '0;
            wb_result_q  <= '0;
            wb_we_q      <= 1'b0;
            wb_wa_q      <= '0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            pend_we_q    <= pend_we_d;
            pend_wa_q    <= pend_wa_d;
            cnt_q        <= cnt_d;
            wb_result_q  <= wb_result_d;
            wb_we_q      <= wb_we_d;
            wb_wa_q      <= wb_wa_d;
            bus_err_q    <= bus_err_d;
            misalign_q   <= misalign_d;
        end
    end

    assign dmem.dmem_req   = dmem_req_q;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_wdata = dmem_wdata_q;
    assign dmem.dmem_be    = dmem_be_q;
    assign WB_result       = wb_result_q;
    assign WB_writeEnable  = wb_we_q;
    assign WB_writeAddress = wb_wa_q;
    assign bus_err         = bus_err_q;
    assign misalign        = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: random and directed MEM-stage traffic against a memory responder, with a
// write-back scoreboard fed by a size/offset reference model.
module tb_mem_access;
    import mem_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_result = '0, mem_addr = '0, mem_data = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  mem_wa = '0;
    logic [5:0]  mem_op = '0;
    logic        stall_req, wb_we, bus_err, misalign;
    logic [31:0] wb_result;
    logic [4:0]  wb_wa;
    logic        vld = 1'b0;

    mem_access_if dmem();

    mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk               (clk),
        .reset             (reset),
        .MEM_result        (mem_result),
        .MEM_writeEnable   (mem_we),
        .MEM_writeAddress  (mem_wa),
        .MEM_ALUopcode     (mem_op),
        .MEM_memoryAddress (mem_addr),
        .MEM_memoryData    (mem_data),
        .dmem              (dmem),
        .stall_req         (stall_req),
        .WB_result         (wb_result),
        .WB_writeEnable    (wb_we),
        .WB_writeAddress   (wb_wa),
        .bus_err           (bus_err),
        .misalign          (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] res; logic we; logic [4:0] wa; logic err, mis, full, res_chk;} wb_t;
    typedef struct {logic [31:0] addr, wdata; logic [3:0] be; logic we, chk_be, chk_wd;} rq_t;
    typedef struct {int lat; logic [31:0] rd;} rs_t;

    wb_t sb[$];
    rq_t rq[$];
    rs_t rs[$];
    int  vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory responder: acks after the queued latency and checks the request bus
    logic        busy = 1'b0;
    int          n, cur_lat;
    logic [31:0] cur_rd, h_addr, h_wd;
    logic [3:0]  h_be;
    logic        h_we;
    rq_t         cur;
    rs_t         rsp;

    always @(negedge clk) begin
        if (!dmem.dmem_req) begin
            busy = 1'b0;
            dmem.dmem_ack = 1'($urandom_range(0, 1));
            dmem.dmem_rdata = $urandom;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                n = 0;
                h_addr = dmem.dmem_addr; h_wd = dmem.dmem_wdata; h_be = dmem.dmem_be; h_we = dmem.dmem_we;
                if (rq.size() == 0 || rs.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_req: addr %h issued with no access pending", dmem.dmem_addr);
                    cur_lat = 1000; cur_rd = '0;
                end else begin
                    cur = rq.pop_front();
                    rsp = rs.pop_front();
                    cur_lat = rsp.lat; cur_rd = rsp.rd;
                    chk("req_addr", dmem.dmem_addr, cur.addr);
                    chk("req_we", dmem.dmem_we, cur.we);
                    if (cur.chk_be) chk("req_be", dmem.dmem_be, cur.be);
                    if (cur.chk_wd) chk("req_wdata", dmem.dmem_wdata, cur.wdata);
                end
            end else begin
                chk("req_stable", {dmem.dmem_addr == h_addr, dmem.dmem_wdata == h_wd,
                                   dmem.dmem_be == h_be, dmem.dmem_we == h_we}, 4'hF);
            end
            dmem.dmem_ack = n == cur_lat;
            dmem.dmem_rdata = dmem.dmem_ack ? cur_rd : $urandom;
            n++;
        end
    end

    // Write-back monitor: an instruction retires on an edge without stall, or by a bus error
    logic m_v, m_s;
    wb_t  m_e;

    always begin
        @(negedge clk); #1;
        m_v = vld; m_s = stall_req;
        @(posedge clk); #1;
        if (reset && ((m_v && !m_s) || bus_err)) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL retire: write-back with empty scoreboard, WB_result %h", wb_result);
            end else begin
                m_e = sb.pop_front();
                chk("wb_we", wb_we, m_e.we);
                chk("bus_err", bus_err, m_e.err);
                chk("misalign", misalign, m_e.mis);
                if (m_e.full) chk("wb_wa", wb_wa, m_e.wa);
                if (m_e.res_chk) chk("wb_result", wb_result, m_e.res);
            end
        end
    end

    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] res, input logic we, input logic [4:0] wa,
                       input int lat, input logic [31:0] rd);
        int sz, off, edges, exp_stall, stalls;
        bit sgn, st, mem, mis, trap;
        logic [31:0] m, v, wd;
        wb_t e;
        rq_t r;
        rs_t p;
        sz = 0; sgn = 0; st = 0; mis = 0; off = 0;
        case (op)
            6'h20: begin sz = 1; sgn = 1; end
            6'h21: begin sz = 2; sgn = 1; end
            6'h23: sz = 4;
            6'h24: sz = 1;
            6'h25: sz = 2;
            6'h28: begin sz = 1; st = 1; end
            6'h29: begin sz = 2; st = 1; end
            6'h2B: begin sz = 4; st = 1; end
            default: sz = 0;
        endcase
        mem = sz != 0;
        if (mem) begin
            mis = (int'(a[1:0]) % sz) != 0;
            off = int'(a[1:0]) - int'(a[1:0]) % sz;
        end
        trap = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = mis;
`endif
        e.res = res; e.we = 0; e.wa = wa; e.err = 0; e.mis = 0; e.full = 1; e.res_chk = 0;
        if (!mem || trap) begin
            e.we = mem ? 1'b0 : we;
            e.mis = trap;
            e.res_chk = !mem;
            edges = 1; exp_stall = 0;
        end else begin
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
            r.addr = {a[31:2], 2'b00}; r.we = st; r.be = 4'(((1 << sz) - 1) << off);
            r.wdata = wd; r.chk_be = st || sz == 4; r.chk_wd = st;
            rq.push_back(r);
            p.lat = lat; p.rd = rd;
            rs.push_back(p);
            if (lat < T) begin
                m = sz == 4 ? 32'hFFFF_FFFF : (32'h1 << (8*sz)) - 1;
                v = (rd >> (8*off)) & m;
                if (sgn && v[8*sz-1]) v = v | ~m;
                e.res = v; e.we = st ? 1'b0 : we; e.res_chk = !st;
                edges = lat + 2; exp_stall = lat + 1;
            end else begin
                e.err = 1; e.full = 0;
                edges = T + 1; exp_stall = T + 1;
            end
        end
        sb.push_back(e);
        mem_op = op; mem_addr = a; mem_data = sd; mem_result = res; mem_we = we; mem_wa = wa;
        vld = 1'b1;
        stalls = 0;
        for (int i = 0; i < edges; i++) begin
            @(negedge clk); #1;
            if (stall_req) stalls++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", stalls, exp_stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        rq_t r;
        rs_t p;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", dmem.dmem_req, 0);
        chk("rst_we", dmem.dmem_we, 0);
        chk("rst_addr", dmem.dmem_addr, 0);
        chk("rst_wdata", dmem.dmem_wdata, 0);
        chk("rst_be", dmem.dmem_be, 0);
        chk("rst_wb", {wb_result, wb_we, wb_wa, bus_err, misalign}, 0);
        reset = 1'b1;

        run(6'h00, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 5'd9, 0, 32'h0);
        run(OP_LW, 32'h100, 32'h0, 32'h0, 1'b1, 5'd3, 3, 32'hDEAD_BEEF);
        run(OP_SB, 32'h203, 32'h0000_00A5, 32'h0, 1'b1, 5'd4, 0, 32'h0);
        run(OP_LB, 32'h1, 32'h0, 32'h0, 1'b1, 5'd5, 1, 32'h0000_8000);
        run(OP_LBU, 32'h1, 32'h0, 32'h0, 1'b1, 5'd6, 2, 32'h0000_8000);
        run(OP_LW, 32'h40, 32'h0, 32'h0, 1'b1, 5'd7, T + 3, 32'h0);
        run(OP_SH, 32'h312, 32'hCAFE_1234, 32'h0, 1'b1, 5'd8, 0, 32'h0);
        run(OP_LHU, 32'h52, 32'h0, 32'h0, 1'b1, 5'd10, T - 1, 32'h9876_5432);
`ifdef MEM_MISALIGN_TRAP_EN
        run(OP_LW, 32'h102, 32'h0, 32'h0, 1'b1, 5'd11, 0, 32'h0);
`endif
        for (int i = 0; i < 300; i++)
            run($urandom_range(0, 1) ? ops[$urandom_range(0, 7)] : 6'($urandom), $urandom, $urandom,
                $urandom, 1'($urandom), 5'($urandom), $urandom_range(0, T + 1), $urandom);

        vld = 1'b0;
        mem_op = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("req_drained", rq.size(), 0);

        // abandon an access with reset in its second WAIT cycle
        r.addr = 32'h300; r.wdata = '0; r.be = 4'hF; r.we = 1'b0; r.chk_be = 1'b1; r.chk_wd = 1'b0;
        rq.push_back(r);
        p.lat = 20; p.rd = '0;
        rs.push_back(p);
        mem_op = OP_LW; mem_addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", dmem.dmem_req, 1);
        reset = 1'b0;
        mem_op = 6'h00;
        @(posedge clk); #1;
        chk("wait_rst_req", dmem.dmem_req, 0);
        chk("wait_rst_bus", {dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, dmem.dmem_be}, 0);
        chk("wait_rst_wb", {wb_result, wb_we, wb_wa, bus_err, misalign}, 0);
        chk("wait_rst_stall", stall_req, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
